// File: rtl/out_sched.sv
// Left/right frame scheduler feeding a parallel-to-serial transmitter.
// Define OUT_SCHED_REPEAT_EN to resend the last channel word on underrun.
`timescale 1ns/1ps
module out_sched #(
  parameter int DATA_W   = 40,
  parameter int START_TO = 4
) (
  input  logic              SCLK,
  input  logic              CLR_N,
  input  logic              START,
  input  logic              FRAME_IN,
  input  logic              L_VALID,
  input  logic [DATA_W-1:0] L_DATA,
  output logic              L_READY,
  input  logic              R_VALID,
  input  logic [DATA_W-1:0] R_DATA,
  output logic              R_READY,
  output logic              P2S_FRAME,
  output logic              P2S_EN,
  output logic [DATA_W-1:0] P2S_DATA,
  input  logic              P2S_BUSY,
  output logic              SLOT,
  output logic              DONE,
  input  logic              ERR_CLR,
  output logic              UNDR_L,
  output logic              UNDR_R,
  output logic              FRAME_MISS,
  output logic              START_ERR
);

  localparam int CW = $clog2(START_TO + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(START_TO - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_FRAME, LOAD_L, SEND_L, LOAD_R, SEND_R
  } st_t;

  st_t state, state_n;

  logic              l_full, r_full;
  logic              l_full_n, r_full_n;
  logic [DATA_W-1:0] l_buf, r_buf;
  logic [DATA_W-1:0] l_buf_n, r_buf_n;
  logic [DATA_W-1:0] und_l, und_r;
  logic [DATA_W-1:0] l_word, r_word;
  logic              l_took, r_took;
  logic              seen;
  logic [CW-1:0]     wcnt;
  logic              abort, fin;

  always_comb begin
    state_n = state;
    abort   = 1'b0;
    fin     = 1'b0;
    unique case (state)
      IDLE: if (START) state_n = WAIT_FRAME;
      WAIT_FRAME: begin
        if (!START) state_n = IDLE;
        else if (FRAME_IN) state_n = LOAD_L;
      end
      LOAD_L: state_n = SEND_L;
      LOAD_R: state_n = SEND_R;
      SEND_L, SEND_R: begin
        if (!seen) begin
          if (!P2S_BUSY && wcnt == TO_LAST) begin
            abort   = 1'b1;
            state_n = WAIT_FRAME;
          end
        end else if (!P2S_BUSY) begin
          if (state == SEND_L) begin
            state_n = LOAD_R;
          end else begin
            fin     = 1'b1;
            state_n = START ? WAIT_FRAME : IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // An aborted transfer puts its word back if no newer sample took the slot.
  always_comb begin
    l_full_n = l_full;
    l_buf_n  = l_buf;
    if (L_VALID && L_READY) begin
      l_full_n = 1'b1;
      l_buf_n  = L_DATA;
    end else if (state == LOAD_L) begin
      l_full_n = 1'b0;
    end else if (abort && state == SEND_L && l_took) begin
      l_full_n = 1'b1;
    end
  end

  always_comb begin
    r_full_n = r_full;
    r_buf_n  = r_buf;
    if (R_VALID && R_READY) begin
      r_full_n = 1'b1;
      r_buf_n  = R_DATA;
    end else if (state == LOAD_R) begin
      r_full_n = 1'b0;
    end else if (abort && state == SEND_R && r_took) begin
      r_full_n = 1'b1;
    end
  end

  assign l_word = l_full_n ? l_buf_n : und_l;
  assign r_word = r_full_n ? r_buf_n : und_r;

`ifdef OUT_SCHED_REPEAT_EN
  logic [DATA_W-1:0] last_l, last_r;

  always_ff @(posedge SCLK or negedge CLR_N) begin
    if (!CLR_N) begin
      last_l <= '0;
      last_r <= '0;
    end else begin
      if (state_n == LOAD_L) last_l <= l_word;
      if (state_n == LOAD_R) last_r <= r_word;
    end
  end

  assign und_l = last_l;
  assign und_r = last_r;
`else
  assign und_l = '0;
  assign und_r = '0;
`endif

  always_ff @(posedge SCLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state     <= IDLE;
      P2S_EN    <= 1'b0;
      P2S_FRAME <= 1'b0;
      P2S_DATA  <= '0;
      SLOT      <= 1'b0;
      DONE      <= 1'b0;
      l_took    <= 1'b0;
      r_took    <= 1'b0;
      seen      <= 1'b0;
      wcnt      <= '0;
    end else begin
      state     <= state_n;
      P2S_EN    <= state_n != IDLE;
      P2S_FRAME <= state_n == LOAD_L || state_n == LOAD_R;
      SLOT      <= state_n == LOAD_R || state_n == SEND_R;
      DONE      <= fin;
      if (state_n == LOAD_L) begin
        P2S_DATA <= l_word;
        l_took   <= l_full_n;
      end else if (state_n == LOAD_R) begin
        P2S_DATA <= r_word;
        r_took   <= r_full_n;
      end
      if (state == LOAD_L || state == LOAD_R) begin
        seen <= 1'b0;
        wcnt <= '0;
      end else if ((state == SEND_L || state == SEND_R) && !seen) begin
        if (P2S_BUSY) seen <= 1'b1;
        else wcnt <= wcnt + CW'(1);
      end
    end
  end

  always_ff @(posedge SCLK or negedge CLR_N) begin
    if (!CLR_N) begin
      l_full     <= 1'b0;
      r_full     <= 1'b0;
      l_buf      <= '0;
      r_buf      <= '0;
      L_READY    <= 1'b0;
      R_READY    <= 1'b0;
      UNDR_L     <= 1'b0;
      UNDR_R     <= 1'b0;
      FRAME_MISS <= 1'b0;
      START_ERR  <= 1'b0;
    end else begin
      l_full     <= l_full_n;
      r_full     <= r_full_n;
      l_buf      <= l_buf_n;
      r_buf      <= r_buf_n;
      L_READY    <= !l_full_n;
      R_READY    <= !r_full_n;
      UNDR_L     <= (state == LOAD_L && !l_full) | (UNDR_L & !ERR_CLR);
      UNDR_R     <= (state == LOAD_R && !r_full) | (UNDR_R & !ERR_CLR);
      FRAME_MISS <= (FRAME_IN && state != WAIT_FRAME)
                  | (FRAME_MISS & !ERR_CLR);
      START_ERR  <= abort | (START_ERR & !ERR_CLR);
    end
  end

endmodule

// File: tb/tb_out_sched.sv
// Directed bench for out_sched with a frame-level reference model.
// Underrun expectations follow OUT_SCHED_REPEAT_EN when defined.
`timescale 1ns/1ps
module tb_out_sched;
  localparam int DW = 40;
  localparam int TO = 4;

  logic SCLK = 0, CLR_N = 0, START = 0, FRAME_IN = 0;
  logic L_VALID = 0, R_VALID = 0, P2S_BUSY = 0, ERR_CLR = 0;
  logic [DW-1:0] L_DATA = '0, R_DATA = '0;
  logic L_READY, R_READY, P2S_FRAME, P2S_EN, SLOT, DONE;
  logic UNDR_L, UNDR_R, FRAME_MISS, START_ERR;
  logic [DW-1:0] P2S_DATA;

  always #5 SCLK = ~SCLK;

  out_sched #(.DATA_W(DW), .START_TO(TO)) dut (
    .SCLK(SCLK), .CLR_N(CLR_N), .START(START), .FRAME_IN(FRAME_IN),
    .L_VALID(L_VALID), .L_DATA(L_DATA), .L_READY(L_READY),
    .R_VALID(R_VALID), .R_DATA(R_DATA), .R_READY(R_READY),
    .P2S_FRAME(P2S_FRAME), .P2S_EN(P2S_EN), .P2S_DATA(P2S_DATA),
    .P2S_BUSY(P2S_BUSY), .SLOT(SLOT), .DONE(DONE), .ERR_CLR(ERR_CLR),
    .UNDR_L(UNDR_L), .UNDR_R(UNDR_R), .FRAME_MISS(FRAME_MISS),
    .START_ERR(START_ERR)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // serializer stand-in: busy for busy_len cycles after each frame pulse
  int busy_len = 10;
  bit dead = 0;
  int bcnt = 0;
  int done_cnt = 0;
  logic [DW-1:0] sent_q[$];

  initial forever begin
    @(negedge SCLK);
    if (!CLR_N) begin
      bcnt = 0;
      P2S_BUSY = 0;
    end else begin
      if (bcnt > 0) begin
        P2S_BUSY = 1;
        bcnt--;
      end else begin
        P2S_BUSY = 0;
      end
      if (P2S_FRAME) begin
        sent_q.push_back(P2S_DATA);
        if (!dead) bcnt = busy_len;
      end
      if (DONE) done_cnt++;
    end
  end

  // reference model: md 0 idle, 1 waiting for frame, 2 in a frame
  int md, waited;
  bit ch, ld, seen;
  logic [DW-1:0] qL[$], qR[$];
  bit tookL, tookR;
  logic [DW-1:0] lastL, lastR, m_data;
  bit m_done, rdyL, rdyR, fUL, fUR, fFM, fSE;

  function automatic logic [DW-1:0] und_word(input logic [DW-1:0] last);
`ifdef OUT_SCHED_REPEAT_EN
    return last;
`else
    return '0;
`endif
  endfunction

  task automatic mreset();
    md = 0; waited = 0; ch = 0; ld = 0; seen = 0;
    qL.delete(); qR.delete();
    tookL = 0; tookR = 0; lastL = '0; lastR = '0; m_data = '0;
    m_done = 0; rdyL = 0; rdyR = 0;
    fUL = 0; fUR = 0; fFM = 0; fSE = 0;
  endtask

  task automatic enter(input bit c);
    ch = c; ld = 1; seen = 0; waited = 0;
    if (!c) begin
      tookL = qL.size() != 0;
      m_data = tookL ? qL[0] : und_word(lastL);
      lastL = m_data;
    end else begin
      tookR = qR.size() != 0;
      m_data = tookR ? qR[0] : und_word(lastR);
      lastR = m_data;
    end
  endtask

  task automatic mstep();
    bit sUL, sUR, sFM, sSE, aL, aR, was_ld;
    sUL = 0; sUR = 0; sSE = 0;
    aL = L_VALID && rdyL;
    aR = R_VALID && rdyR;
    sFM = FRAME_IN && md != 1;
    m_done = 0;
    was_ld = md == 2 && ld;
    if (was_ld) begin
      if (!ch) begin
        if (qL.size() != 0) void'(qL.pop_front()); else sUL = 1;
      end else begin
        if (qR.size() != 0) void'(qR.pop_front()); else sUR = 1;
      end
      ld = 0;
    end
    if (aL) qL.push_back(L_DATA);
    if (aR) qR.push_back(R_DATA);
    case (md)
      0: if (START) md = 1;
      1: if (!START) md = 0;
         else if (FRAME_IN) begin md = 2; enter(0); end
      default: if (!was_ld) begin
        if (!seen) begin
          if (P2S_BUSY) seen = 1;
          else begin
            waited++;
            if (waited == TO) begin
              sSE = 1; md = 1;
              if (!ch && tookL && qL.size() == 0) qL.push_back(m_data);
              if (ch && tookR && qR.size() == 0) qR.push_back(m_data);
            end
          end
        end else if (!P2S_BUSY) begin
          if (!ch) enter(1);
          else begin m_done = 1; md = START ? 1 : 0; end
        end
      end
    endcase
    rdyL = qL.size() == 0;
    rdyR = qR.size() == 0;
    fUL = sUL | (fUL & !ERR_CLR);
    fUR = sUR | (fUR & !ERR_CLR);
    fFM = sFM | (fFM & !ERR_CLR);
    fSE = sSE | (fSE & !ERR_CLR);
  endtask

  always @(posedge SCLK or negedge CLR_N) begin
    if (!CLR_N) mreset();
    else mstep();
  end

  always @(posedge SCLK) begin
    #1;
    chk("cyc_ctl",
        {P2S_FRAME, P2S_EN, SLOT, DONE, L_READY, R_READY,
         UNDR_L, UNDR_R, FRAME_MISS, START_ERR},
        {md == 2 && ld, md != 0, md == 2 && ch, m_done, rdyL, rdyR,
         fUL, fUR, fFM, fSE});
    chk("cyc_data", P2S_DATA, m_data);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge SCLK);
  endtask

  task automatic push_lr(input bit dl, input logic [DW-1:0] l,
                         input bit dr, input logic [DW-1:0] r);
    @(negedge SCLK);
    L_VALID = dl; L_DATA = l;
    R_VALID = dr; R_DATA = r;
    @(negedge SCLK);
    L_VALID = 0; R_VALID = 0;
  endtask

  task automatic pulse_frame();
    @(negedge SCLK); FRAME_IN = 1;
    @(negedge SCLK); FRAME_IN = 0;
  endtask

  task automatic clr_flags();
    @(negedge SCLK); ERR_CLR = 1;
    @(negedge SCLK); ERR_CLR = 0;
  endtask

  task automatic wait_done(input string nm, input int base);
    int k = 0;
    while (done_cnt == base && k < 300) begin
      @(negedge SCLK); #1; k++;
    end
    chk(nm, done_cnt != base, 1);
  endtask

  task automatic wait_send(input string nm, input bit c);
    int k = 0;
    while (!(SLOT == c && P2S_BUSY) && k < 200) begin
      @(negedge SCLK); #1; k++;
    end
    chk(nm, SLOT == c && P2S_BUSY, 1);
  endtask

  localparam logic [DW-1:0] WL = 40'h80_0000_0001;
  localparam logic [DW-1:0] WR = 40'h00_FFFF_FFFE;
  localparam logic [DW-1:0] WP = 40'h12_3456_789A;
`ifdef OUT_SCHED_REPEAT_EN
  localparam logic [DW-1:0] UND_R = WP;
`else
  localparam logic [DW-1:0] UND_R = '0;
`endif

  initial begin
    int base, k;
    tick(3); #1;
    chk("rst_outs",
        {P2S_FRAME, P2S_EN, SLOT, DONE, L_READY, R_READY,
         UNDR_L, UNDR_R, FRAME_MISS, START_ERR}, 0);
    chk("rst_data", P2S_DATA, 0);
    @(negedge SCLK); CLR_N = 1;
    @(posedge SCLK); #1;
    chk("rdy_rise", {L_READY, R_READY}, 2'b11);

    // nominal frame
    @(negedge SCLK); START = 1;
    push_lr(1, WL, 1, WR);
    sent_q.delete();
    base = done_cnt;
    pulse_frame(); #1;
    chk("nom_frame_t1", P2S_FRAME, 1);
    chk("nom_data_l", P2S_DATA, WL);
    wait_done("nom_done", base);
    chk("nom_nsent", sent_q.size(), 2);
    chk("nom_word_l", sent_q[0], WL);
    chk("nom_word_r", sent_q[1], WR);
    chk("nom_ndone", done_cnt - base, 1);
    chk("nom_ready", {L_READY, R_READY}, 2'b11);

    // right underrun after a known right word
    push_lr(1, 40'h00_0000_00AA, 1, WP);
    base = done_cnt;
    pulse_frame();
    wait_done("und_pre_done", base);
    push_lr(1, 40'h00_0000_00BB, 0, '0);
    sent_q.delete();
    base = done_cnt;
    pulse_frame();
    wait_done("und_done", base);
    chk("und_word_l", sent_q[0], 40'h00_0000_00BB);
    chk("und_word_r", sent_q[1], UND_R);
    chk("und_flags", {UNDR_L, UNDR_R}, 2'b01);
    clr_flags(); #1;
    chk("und_clr", UNDR_R, 0);

    // stray frame pulse mid-frame, cleared in the same cycle
    push_lr(1, 40'h0F_0F0F_0F0F, 1, 40'hF0_F0F0_F0F0);
    sent_q.delete();
    base = done_cnt;
    pulse_frame();
    wait_send("miss_send_l", 0);
    @(negedge SCLK); FRAME_IN = 1; ERR_CLR = 1;
    @(negedge SCLK); FRAME_IN = 0; ERR_CLR = 0; #1;
    chk("miss_flag", FRAME_MISS, 1);
    wait_done("miss_done", base);
    tick(6);
    chk("miss_ndone", done_cnt - base, 1);
    chk("miss_nsent", sent_q.size(), 2);
    clr_flags();

    // serializer never starts
    dead = 1;
    push_lr(1, 40'h55_AAAA_5555, 0, '0);
    @(negedge SCLK); FRAME_IN = 1;
    @(negedge SCLK); FRAME_IN = 0;
    k = 0;
    #1;
    while (!START_ERR && k < 20) begin
      @(negedge SCLK); #1; k++;
    end
    chk("serr_lat", k, 5);
    chk("serr_state", {P2S_EN, SLOT, P2S_FRAME}, 3'b100);
    chk("serr_kept", L_READY, 0);
    dead = 0;
    push_lr(0, '0, 1, 40'h01_0203_0405);
    sent_q.delete();
    base = done_cnt;
    pulse_frame();
    wait_done("serr_retry_done", base);
    chk("serr_retry_l", sent_q[0], 40'h55_AAAA_5555);
    chk("serr_no_undr", UNDR_L, 0);
    clr_flags();

    // reset in the middle of the right transfer
    busy_len = 40;
    push_lr(1, 40'h11_1111_1111, 1, 40'h22_2222_2222);
    base = done_cnt;
    pulse_frame();
    wait_send("rst_send_r", 1);
    tick(19);
    CLR_N = 0; #1;
    chk("rst_mid_outs",
        {P2S_FRAME, P2S_EN, SLOT, DONE, L_READY, R_READY,
         UNDR_L, UNDR_R, FRAME_MISS, START_ERR}, 0);
    chk("rst_mid_data", P2S_DATA, 0);
    tick(2);
    CLR_N = 1;
    @(posedge SCLK); #1;
    chk("rst_mid_rdy", {L_READY, R_READY}, 2'b11);
    tick(5);
    chk("rst_mid_nodone", done_cnt - base, 0);
    busy_len = 10;

    // START dropped during the left transfer
    push_lr(1, 40'h33_3333_3333, 1, 40'h44_4444_4444);
    sent_q.delete();
    base = done_cnt;
    pulse_frame();
    wait_send("drop_send_l", 0);
    @(negedge SCLK); START = 0;
    wait_done("drop_done", base);
    chk("drop_en", P2S_EN, 0);
    chk("drop_word_r", sent_q[1], 40'h44_4444_4444);
    tick(4);
    chk("drop_ndone", done_cnt - base, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
